// File: rtl/cga_intr_cntlr_vecgen_isrd_if.sv
// Bus bundle between the ISMUX status outputs / CPU read handshake and the
// FIDB read-back block.
interface cga_intr_cntlr_vecgen_isrd_if #(
  parameter int W = 3
) ();
  logic [W-1:0] LOSIN_2_0;
  logic [W-1:0] HISIN_2_0;
  logic         LOLDN;
  logic         HILDN;
  logic         RDREQN;
  logic         RDSELHI;
  logic [W-1:0] FIDBI_2_0;
  logic         BUSOEN;
  logic         RDACKN;
  logic         LOPENDN;
  logic         HIPENDN;
  logic         INTPN;

  modport master (
    output LOSIN_2_0, HISIN_2_0, LOLDN, HILDN, RDREQN, RDSELHI,
    input  FIDBI_2_0, BUSOEN, RDACKN, LOPENDN, HIPENDN, INTPN
  );

  modport slave (
    input  LOSIN_2_0, HISIN_2_0, LOLDN, HILDN, RDREQN, RDSELHI,
    output FIDBI_2_0, BUSOEN, RDACKN, LOPENDN, HIPENDN, INTPN
  );
endinterface

// File: rtl/cga_intr_cntlr_vecgen_isrd.sv
// Interrupt status read-back: holds LO/HI group status and pending flags and
// returns the selected group on the FIDB bus under a CPU read handshake.
module cga_intr_cntlr_vecgen_isrd #(
  parameter int W           = 3,
  parameter int ACK_HOLD    = 1,
  parameter int CLR_ON_READ = 1
) (
  input  logic                           MCLK,
  input  logic                           MRSTN,
  cga_intr_cntlr_vecgen_isrd_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, CAPT, DRIVE, ACK, WAITREL} state_e;

  localparam logic [1:0] ACK_LAST = 2'(ACK_HOLD - 1);

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         sel_q, sel_d;
  logic [W-1:0] snap_q, snap_d;
  logic [W-1:0] lo_stat_q, lo_stat_d;
  logic [W-1:0] hi_stat_q, hi_stat_d;
  logic         lo_pend_q, lo_pend_d;
  logic         hi_pend_q, hi_pend_d;
  logic [W-1:0] fidbi_q, fidbi_d;
  logic         busoen_q, busoen_d;
  logic         rdackn_q, rdackn_d;
  logic         intpn_q, intpn_d;
  logic         ack_entry;
  logic         drive;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    snap_d    = snap_q;
    lo_stat_d = lo_stat_q;
    hi_stat_d = hi_stat_q;
    lo_pend_d = lo_pend_q;
    hi_pend_d = hi_pend_q;
    ack_entry = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.RDREQN) state_d = CAPT;
      end
      CAPT: begin
        if (bus.RDREQN) begin
          state_d = IDLE;
        end else begin
          // Snapshot uses the pre-edge register, so a same-edge load is not seen
          sel_d   = bus.RDSELHI;
          snap_d  = bus.RDSELHI ? hi_stat_q : lo_stat_q;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.RDREQN) begin
          state_d = IDLE;
        end else begin
          state_d   = ACK;
          cnt_d     = '0;
          ack_entry = 1'b1;
        end
      end
      ACK: begin
        if (cnt_q == ACK_LAST) state_d = WAITREL;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      WAITREL: begin
        if (bus.RDREQN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (ack_entry && (CLR_ON_READ != 0)) begin
      if (sel_q) hi_pend_d = 1'b0;
      else       lo_pend_d = 1'b0;
    end

    // Loads are applied after the clear so a new nonzero event always wins
    if (!bus.LOLDN) begin
      lo_stat_d = bus.LOSIN_2_0;
      if (|bus.LOSIN_2_0) lo_pend_d = 1'b1;
    end
    if (!bus.HILDN) begin
      hi_stat_d = bus.HISIN_2_0;
      if (|bus.HISIN_2_0) hi_pend_d = 1'b1;
    end

    // Bus outputs lag the state by one edge
    drive    = state_q inside {DRIVE, ACK, WAITREL};
    busoen_d = !drive;
    rdackn_d = (state_q != ACK);
    fidbi_d  = drive ? snap_q : '0;
    intpn_d  = !(lo_pend_d || hi_pend_d);
  end

  always_ff @(posedge MCLK) begin
    if (!MRSTN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      snap_q    <= '0;
      lo_stat_q <= '0;
      hi_stat_q <= '0;
      lo_pend_q <= 1'b0;
      hi_pend_q <= 1'b0;
      fidbi_q   <= '0;
      busoen_q  <= 1'b1;
      rdackn_q  <= 1'b1;
      intpn_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      snap_q    <= snap_d;
      lo_stat_q <= lo_stat_d;
      hi_stat_q <= hi_stat_d;
      lo_pend_q <= lo_pend_d;
      hi_pend_q <= hi_pend_d;
      fidbi_q   <= fidbi_d;
      busoen_q  <= busoen_d;
      rdackn_q  <= rdackn_d;
      intpn_q   <= intpn_d;
    end
  end

  assign bus.FIDBI_2_0 = fidbi_q;
  assign bus.BUSOEN    = busoen_q;
  assign bus.RDACKN    = rdackn_q;
  assign bus.LOPENDN   = !lo_pend_q;
  assign bus.HIPENDN   = !hi_pend_q;
  assign bus.INTPN     = intpn_q;

endmodule

// File: tb/tb_cga_intr_cntlr_vecgen_isrd.sv
// Bench for the interrupt status read-back block: a cycle table with a
// scoreboard queue for the default build, plus a hand sequence for ACK_HOLD=3.
module tb_cga_intr_cntlr_vecgen_isrd;

  typedef struct {
    logic       rstn;
    logic [2:0] lo, hi;
    logic       loldn, hildn, req, sel;
    logic [2:0] fid;
    logic       oen, ack, lop, hip, intp;
  } vec_t;

  logic MCLK;
  logic MRSTN;
  logic MRSTN3;
  int   total = 0;
  int   bad   = 0;

  cga_intr_cntlr_vecgen_isrd_if #(.W(3)) bus_if  ();
  cga_intr_cntlr_vecgen_isrd_if #(.W(3)) bus3_if ();

  cga_intr_cntlr_vecgen_isrd #(.W(3), .ACK_HOLD(1), .CLR_ON_READ(1)) dut (
    .MCLK (MCLK),
    .MRSTN(MRSTN),
    .bus  (bus_if)
  );

  cga_intr_cntlr_vecgen_isrd #(.W(3), .ACK_HOLD(3), .CLR_ON_READ(0)) dut3 (
    .MCLK (MCLK),
    .MRSTN(MRSTN3),
    .bus  (bus3_if)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  function automatic vec_t mk(int r, int lo, int hi, int ll, int hl, int rq, int sl,
                              int fd, int oe, int ak, int lp, int hp, int ip);
    vec_t v;
    v.rstn = 1'(r);  v.lo = 3'(lo);  v.hi = 3'(hi);
    v.loldn = 1'(ll); v.hildn = 1'(hl); v.req = 1'(rq); v.sel = 1'(sl);
    v.fid = 3'(fd);  v.oen = 1'(oe); v.ack = 1'(ak);
    v.lop = 1'(lp);  v.hip = 1'(hp); v.intp = 1'(ip);
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d want=%0d", nm, row, act, exp);
    end
  endtask

  vec_t vecs[$];
  vec_t exp_q[$];

  initial begin
    vec_t e;
    int   first_oen, first_ack, ack_cnt, last_oen_low;
    logic [2:0] fid_drv;

    //            rst lo hi lld hld req sel | fid oen ack lop hip int
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0,   0, 1, 1, 1, 1, 1)); // 0 reset
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0,   0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 5, 0, 0, 1, 1, 0,   0, 1, 1, 0, 1, 0)); // 3 load LO=101
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 1, 0)); // 4 read LO, edge k
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   5, 0, 1, 1, 1, 1)); // k+2 drive, ACK entry clear
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   5, 0, 0, 1, 1, 1)); // k+3 ack
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   5, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   5, 0, 1, 1, 1, 1)); // 9 release sampled
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0,   0, 1, 1, 0, 0, 0)); // 11 load both
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1,   0, 1, 1, 0, 0, 0)); // 12 read HI
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   3, 0, 1, 0, 1, 0)); // sel change ignored
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   3, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   3, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 1, 0,   0, 1, 1, 0, 0, 0)); // 18 HI=001
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 6, 1, 0, 0, 1,   0, 1, 1, 0, 0, 0)); // 20 load on CAPT edge
    vecs.push_back(mk(1, 0, 2, 1, 0, 0, 1,   1, 0, 1, 0, 0, 0)); // 21 load on ACK entry
    vecs.push_back(mk(1, 0, 7, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0)); // reload while driven
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0)); // 25 abort in DRIVE
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0)); // 30 abort in CAPT
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0,   0, 1, 1, 0, 0, 0)); // 33 zero load keeps flag
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 0, 1, 1, 0, 0)); // held in WAITREL
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1,   0, 1, 1, 1, 0, 0)); // 41 read then reset in DRIVE
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1,   0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1,   0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1,   0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 1, 1, 1, 1, 1));

    MRSTN3 = 1'b0;
    bus3_if.LOSIN_2_0 = '0; bus3_if.HISIN_2_0 = '0;
    bus3_if.LOLDN = 1'b1;   bus3_if.HILDN = 1'b1;
    bus3_if.RDREQN = 1'b1;  bus3_if.RDSELHI = 1'b0;

    foreach (vecs[i]) begin
      MRSTN             = vecs[i].rstn;
      bus_if.LOSIN_2_0  = vecs[i].lo;
      bus_if.HISIN_2_0  = vecs[i].hi;
      bus_if.LOLDN      = vecs[i].loldn;
      bus_if.HILDN      = vecs[i].hildn;
      bus_if.RDREQN     = vecs[i].req;
      bus_if.RDSELHI    = vecs[i].sel;
      exp_q.push_back(vecs[i]);
      @(posedge MCLK); #1;
      e = exp_q.pop_front();
      chk("FIDBI",   i, bus_if.FIDBI_2_0,   e.fid);
      chk("BUSOEN",  i, 3'(bus_if.BUSOEN),  3'(e.oen));
      chk("RDACKN",  i, 3'(bus_if.RDACKN),  3'(e.ack));
      chk("LOPENDN", i, 3'(bus_if.LOPENDN), 3'(e.lop));
      chk("HIPENDN", i, 3'(bus_if.HIPENDN), 3'(e.hip));
      chk("INTPN",   i, 3'(bus_if.INTPN),   3'(e.intp));
    end

    // ACK_HOLD=3, CLR_ON_READ=0 variant
    @(posedge MCLK); #1;
    @(posedge MCLK); #1;
    MRSTN3 = 1'b1;
    @(posedge MCLK); #1;
    bus3_if.LOSIN_2_0 = 3'd5; bus3_if.LOLDN = 1'b0;
    @(posedge MCLK); #1;
    bus3_if.LOLDN = 1'b1; bus3_if.LOSIN_2_0 = '0;
    chk("V3_LOPENDN_LOAD", 0, 3'(bus3_if.LOPENDN), 3'd0);
    bus3_if.RDREQN = 1'b0; bus3_if.RDSELHI = 1'b0;
    first_oen = -1; first_ack = -1; ack_cnt = 0; last_oen_low = -1; fid_drv = '0;
    for (int n = 0; n < 14; n++) begin
      @(posedge MCLK); #1;
      if (!bus3_if.BUSOEN) begin
        if (first_oen < 0) fid_drv = bus3_if.FIDBI_2_0;
        if (first_oen < 0) first_oen = n;
        last_oen_low = n;
      end
      if (!bus3_if.RDACKN) begin
        ack_cnt++;
        if (first_ack < 0) first_ack = n;
      end
      if (n == 8) bus3_if.RDREQN = 1'b1;
    end
    chk("V3_OEN_LATENCY", 1, 3'(first_oen),    3'd2);
    chk("V3_ACK_LATENCY", 2, 3'(first_ack),    3'd3);
    chk("V3_ACK_CYCLES",  3, 3'(ack_cnt),      3'd3);
    chk("V3_FIDBI",       4, fid_drv,          3'd5);
    chk("V3_RELEASE",     5, 3'(last_oen_low), 3'd1);
    chk("V3_OEN_END",     6, 3'(bus3_if.BUSOEN),  3'd1);
    chk("V3_LOPENDN_END", 7, 3'(bus3_if.LOPENDN), 3'd0);
    chk("V3_INTPN_END",   8, 3'(bus3_if.INTPN),   3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
